// File: rtl/spi_bus_ctrl.sv
// Internal-bus controller behind the SPI gateway: address decode, per-port
// write/read-consume strobes, transmit mux, session word count and error flag.
module spi_bus_ctrl #(
    parameter int          NPORTS   = 4,
    parameter logic [7:0]  BASE     = 8'h00,
    parameter logic [15:0] IDLE_VAL = 16'hDEAD
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [7:0]             ADDR,
    input  logic                   SEL,
    input  logic                   TXE,
    input  logic                   RXE,
    input  logic [15:0]            RXD,
    output logic [15:0]            TXD,
    output logic [15:0]            WR_DATA,
    output logic [NPORTS-1:0]      WR_STB,
    input  logic [16*NPORTS-1:0]   RD_DATA,
    output logic [NPORTS-1:0]      RD_STB,
    output logic [7:0]             WORDS,
    output logic                   ERR
);

    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [7:0] NP8 = 8'(NPORTS);
    localparam logic [NPORTS-1:0] ONE = NPORTS'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        UNMAPPED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              sel_q, sel_d;
    logic              txe_q, txe_d;
    logic [15:0]       txd_q, txd_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic [NPORTS-1:0] wr_stb_q, wr_stb_d;
    logic [NPORTS-1:0] rd_stb_q, rd_stb_d;
    logic [7:0]        words_q, words_d;
    logic              err_q, err_d;

    logic [7:0]        dec;
    logic [IW-1:0]     dec_idx;
    logic              mapped;
    logic              sel_rise;
    logic              txe_fall;
    logic [15:0]       rd_cur;
    logic [15:0]       rd_new;

    assign dec      = ADDR - BASE;
    assign dec_idx  = dec[IW-1:0];
    assign mapped   = (dec < NP8);
    assign sel_rise = SEL && !sel_q;
    assign txe_fall = txe_q && !TXE;

    always_comb begin
        rd_cur = IDLE_VAL;
        rd_new = IDLE_VAL;
        for (int i = 0; i < NPORTS; i++) begin
            if (IW'(i) == idx_q) rd_cur = RD_DATA[16*i +: 16];
            if (IW'(i) == dec_idx) rd_new = RD_DATA[16*i +: 16];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sel_d     = SEL;
        txe_d     = TXE;
        txd_d     = IDLE_VAL;
        wr_data_d = wr_data_q;
        wr_stb_d  = '0;
        rd_stb_d  = '0;
        words_d   = words_q;
        err_d     = err_q;

        // Strobes and the word count act on the state held during this cycle,
        // so an RXE coinciding with SEL falling still lands.
        if (RXE && state_q == ACTIVE) begin
            wr_data_d = RXD;
            wr_stb_d  = ONE << idx_q;
        end
        if (state_q == ACTIVE && txe_fall && SEL) begin
            rd_stb_d = ONE << idx_q;
        end
        if (RXE && state_q != IDLE && words_q != 8'hFF) begin
            words_d = words_q + 8'd1;
        end

        if (!SEL) begin
            state_d = IDLE;
        end else if (sel_rise) begin
            words_d = 8'd0;
            if (mapped) begin
                state_d = ACTIVE;
                idx_d   = dec_idx;
                txd_d   = rd_new;
            end else begin
                state_d = UNMAPPED;
                err_d   = 1'b1;
            end
        end else if (state_q == ACTIVE) begin
            txd_d = rd_cur;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            sel_q     <= 1'b1;
            txe_q     <= 1'b0;
            txd_q     <= IDLE_VAL;
            wr_data_q <= '0;
            wr_stb_q  <= '0;
            rd_stb_q  <= '0;
            words_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            txe_q     <= txe_d;
            txd_q     <= txd_d;
            wr_data_q <= wr_data_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            words_q   <= words_d;
            err_q     <= err_d;
        end
    end

    assign TXD     = txd_q;
    assign WR_DATA = wr_data_q;
    assign WR_STB  = wr_stb_q;
    assign RD_STB  = rd_stb_q;
    assign WORDS   = words_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Directed bench for spi_bus_ctrl with BASE=8'h10, NPORTS=4.
module tb_spi_bus_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [7:0]  ADDR;
    logic        SEL, TXE, RXE;
    logic [15:0] RXD;
    logic [15:0] TXD, WR_DATA;
    logic [3:0]  WR_STB, RD_STB;
    logic [63:0] RD_DATA;
    logic [7:0]  WORDS;
    logic        ERR;

    int errors = 0;
    int checks = 0;

    spi_bus_ctrl #(
        .NPORTS(4),
        .BASE(8'h10),
        .IDLE_VAL(16'hDEAD)
    ) dut (
        .CLK(CLK), .nRST(nRST), .ADDR(ADDR), .SEL(SEL), .TXE(TXE),
        .RXE(RXE), .RXD(RXD), .TXD(TXD), .WR_DATA(WR_DATA),
        .WR_STB(WR_STB), .RD_DATA(RD_DATA), .RD_STB(RD_STB),
        .WORDS(WORDS), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        nRST = 1'b0; ADDR = 8'h00; SEL = 1'b0; TXE = 1'b0;
        RXE = 1'b0; RXD = 16'h0000;
        RD_DATA = {16'h3333, 16'h1234, 16'h1111, 16'h0A0A};
        tick(); tick();
        chk("rst_txd", 32'(TXD), 32'hDEAD);
        chk("rst_wrdata", 32'(WR_DATA), 32'h0);
        chk("rst_wrstb", 32'(WR_STB), 32'h0);
        chk("rst_rdstb", 32'(RD_STB), 32'h0);
        chk("rst_words", 32'(WORDS), 32'h0);
        chk("rst_err", 32'(ERR), 32'h0);
        nRST = 1'b1;
        tick();

        // Session to port 2
        ADDR = 8'h12; SEL = 1'b1; TXE = 1'b1;
        tick();
        chk("p2_txd", 32'(TXD), 32'h1234);
        chk("p2_state", 32'(dut.state_q), 32'd1);
        RD_DATA[47:32] = 16'h5678;
        tick();
        chk("p2_txd_follow", 32'(TXD), 32'h5678);
        TXE = 1'b0;
        tick();
        chk("p2_rdstb", 32'(RD_STB), 32'b0100);
        tick();
        chk("p2_rdstb_clr", 32'(RD_STB), 32'b0000);
        SEL = 1'b0;
        tick();
        chk("p2_idle", 32'(dut.state_q), 32'd0);
        chk("p2_idle_txd", 32'(TXD), 32'hDEAD);

        // Three writes to port 1
        ADDR = 8'h11; SEL = 1'b1;
        tick();
        chk("p1_words0", 32'(WORDS), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            RXE = 1'b1; RXD = 16'hA5A5;
            tick();
            chk("p1_wrstb", 32'(WR_STB), 32'b0010);
            chk("p1_wrdata", 32'(WR_DATA), 32'hA5A5);
            chk("p1_words", 32'(WORDS), 32'(i));
            RXE = 1'b0;
            tick();
            chk("p1_wrstb_clr", 32'(WR_STB), 32'b0000);
        end
        SEL = 1'b0;
        tick();
        chk("words_hold", 32'(WORDS), 32'd3);

        // Unmapped via wrap
        ADDR = 8'h0F; SEL = 1'b1;
        tick();
        chk("um_state", 32'(dut.state_q), 32'd2);
        chk("um_err", 32'(ERR), 32'd1);
        chk("um_txd", 32'(TXD), 32'hDEAD);
        chk("um_words0", 32'(WORDS), 32'd0);
        RXE = 1'b1; RXD = 16'h5555;
        tick();
        chk("um_wrstb", 32'(WR_STB), 32'h0);
        chk("um_words", 32'(WORDS), 32'd1);
        RXE = 1'b0; SEL = 1'b0;
        tick();

        // Valid session keeps ERR; simultaneous strobes
        ADDR = 8'h13; SEL = 1'b1; TXE = 1'b1;
        tick();
        chk("err_sticky", 32'(ERR), 32'd1);
        chk("p3_txd", 32'(TXD), 32'h3333);
        RXE = 1'b1; RXD = 16'hBEEF; TXE = 1'b0;
        tick();
        chk("both_wrstb", 32'(WR_STB), 32'b1000);
        chk("both_rdstb", 32'(RD_STB), 32'b1000);
        chk("both_wrdata", 32'(WR_DATA), 32'hBEEF);
        RXE = 1'b0; TXE = 1'b1;
        tick();
        SEL = 1'b0; TXE = 1'b0;
        tick();
        chk("selfall_rdstb", 32'(RD_STB), 32'h0);
        chk("selfall_state", 32'(dut.state_q), 32'd0);

        // RXE coinciding with SEL fall
        SEL = 1'b1;
        tick();
        RXE = 1'b1; RXD = 16'hC0DE; SEL = 1'b0;
        tick();
        chk("rxe_selfall_wrstb", 32'(WR_STB), 32'b1000);
        chk("rxe_selfall_data", 32'(WR_DATA), 32'hC0DE);
        chk("rxe_selfall_state", 32'(dut.state_q), 32'd0);
        RXE = 1'b0;
        tick();

        // Reset mid-session
        SEL = 1'b1;
        tick();
        nRST = 1'b0;
        tick();
        chk("mrst_err", 32'(ERR), 32'd0);
        chk("mrst_words", 32'(WORDS), 32'd0);
        chk("mrst_txd", 32'(TXD), 32'hDEAD);
        chk("mrst_wrdata", 32'(WR_DATA), 32'h0);
        chk("mrst_state", 32'(dut.state_q), 32'd0);
        nRST = 1'b1;
        tick();
        chk("rel_state", 32'(dut.state_q), 32'd0);
        RXE = 1'b1; RXD = 16'h7777;
        tick();
        chk("rel_wrstb", 32'(WR_STB), 32'h0);
        chk("rel_txd", 32'(TXD), 32'hDEAD);
        RXE = 1'b0; SEL = 1'b0;
        tick();
        ADDR = 8'h10; SEL = 1'b1;
        tick();
        chk("new_state", 32'(dut.state_q), 32'd1);
        chk("new_txd", 32'(TXD), 32'h0A0A);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            RXE = 1'b1; RXD = 16'(i);
            tick();
            RXE = 1'b0;
            tick();
        end
        chk("sat_words", 32'(WORDS), 32'd255);
        chk("sat_wrdata", 32'(WR_DATA), 32'd299);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
